// File: rtl/multi_debounce_toggle.sv
// multi_debounce_toggle: per-channel synchroniser, debounce filter, edge pulses, toggle and long-press detector
module multi_debounce_toggle #(
  parameter int NUM_CH            = 4,
  parameter int DEBOUNCE_LIMIT    = 250000,
  parameter int HOLD_LIMIT        = 12500000,
  parameter int TOGGLE_ON_RELEASE = 1
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [NUM_CH-1:0] i_Bouncy,
  output logic [NUM_CH-1:0] o_Debounced,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic [NUM_CH-1:0] o_Toggle,
  output logic [NUM_CH-1:0] o_Held
);
  localparam int DW = DEBOUNCE_LIMIT > 1 ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int HW = HOLD_LIMIT > 0 ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_LIMIT - 1);
  localparam logic [HW-1:0] H_MAX = HW'(HOLD_LIMIT);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_LIMIT - 1);
  localparam bit HOLD_EN = HOLD_LIMIT != 0;
  localparam bit ON_FALL = TOGGLE_ON_RELEASE != 0;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic s1_q;
    logic s2_q;
    logic deb_q;
    logic deb_d;
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;
    logic tog_q;
    logic tog_d;
    logic held_q;
    logic held_d;
    logic done;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;
    logic [HW-1:0] hcnt_q;
    logic [HW-1:0] hcnt_d;
    // commit a new level after DEBOUNCE_LIMIT disagreeing samples; hold counter saturates so it fires once per press
    always_comb begin
      done = s2_q != deb_q && dcnt_q == D_LAST;
      dcnt_d = (s2_q == deb_q || done) ? '0 : dcnt_q + 1'b1;
      deb_d = done ? s2_q : deb_q;
      rise_d = done && s2_q;
      fall_d = done && !s2_q;
      tog_d = tog_q ^ (ON_FALL ? fall_q : rise_q);
      hcnt_d = !deb_q ? '0 : (hcnt_q == H_MAX ? hcnt_q : hcnt_q + 1'b1);
      held_d = HOLD_EN && deb_q && hcnt_q == H_LAST;
    end
    // channel state; reset discards any partial debounce or hold count
    always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
        deb_q <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        tog_q <= 1'b0;
        held_q <= 1'b0;
        dcnt_q <= '0;
        hcnt_q <= '0;
      end else begin
        s1_q <= i_Bouncy[k];
        s2_q <= s1_q;
        deb_q <= deb_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
        tog_q <= tog_d;
        held_q <= held_d;
        dcnt_q <= dcnt_d;
        hcnt_q <= hcnt_d;
      end
    end
    assign o_Debounced[k] = deb_q;
    assign o_Rise[k] = rise_q;
    assign o_Fall[k] = fall_q;
    assign o_Toggle[k] = tog_q;
    assign o_Held[k] = held_q;
  end
endmodule

// File: tb/tb_multi_debounce_toggle.sv
// tb_multi_debounce_toggle: sliding-window reference with scoreboard, directed corner sequences and a segment table
module tb_multi_debounce_toggle;
  localparam int L = 4;
  localparam int H = 10;
  typedef struct {
    logic [1:0] deb;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] toga;
    logic [1:0] held;
    logic [1:0] togb;
  } exp_t;
  typedef struct {
    logic [1:0] in;
    int cyc;
    logic [1:0] deb;
    logic [1:0] toga;
    logic [1:0] togb;
    int rises;
    int falls;
    int helds;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] bouncy;
  logic [1:0] deb_a, rise_a, fall_a, tog_a, held_a;
  logic [1:0] deb_b, rise_b, fall_b, tog_b, held_b;
  int checks = 0;
  int failures = 0;
  int n = 0;
  exp_t sb[$];
  logic [1:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_rise = '0, m_fall = '0;
  logic [1:0] m_toga = '0, m_togb = '0, m_held = '0;
  logic [L-1:0] m_hist [2];
  int rise_t [2];
  logic b_held_any = 1'b0;
  vec_t tbl [14];

  multi_debounce_toggle #(.NUM_CH(2), .DEBOUNCE_LIMIT(L), .HOLD_LIMIT(H), .TOGGLE_ON_RELEASE(1)) dut_a (
    .i_Clk(clk), .i_Reset(rst), .i_Bouncy(bouncy), .o_Debounced(deb_a), .o_Rise(rise_a),
    .o_Fall(fall_a), .o_Toggle(tog_a), .o_Held(held_a));
  multi_debounce_toggle #(.NUM_CH(2), .DEBOUNCE_LIMIT(L), .HOLD_LIMIT(0), .TOGGLE_ON_RELEASE(0)) dut_b (
    .i_Clk(clk), .i_Reset(rst), .i_Bouncy(bouncy), .o_Debounced(deb_b), .o_Rise(rise_b),
    .o_Fall(fall_b), .o_Toggle(tog_b), .o_Held(held_b));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h want=%h", name, n, act, exp);
    end
  endtask

  // model: the level flips when the last L synchronised samples all disagree with it
  task automatic step(input logic [1:0] b, input logic r);
    exp_t e;
    logic [1:0] nta, ntb;
    logic flip;
    bouncy = b;
    rst = r;
    n++;
    if (r) begin
      m_s1 = '0;
      m_s2 = '0;
      m_deb = '0;
      m_rise = '0;
      m_fall = '0;
      m_toga = '0;
      m_togb = '0;
      m_held = '0;
      m_hist[0] = '0;
      m_hist[1] = '0;
    end else begin
      nta = m_toga ^ m_fall;
      ntb = m_togb ^ m_rise;
      for (int ch = 0; ch < 2; ch++) begin
        m_hist[ch] = {m_hist[ch][L-2:0], m_s2[ch]};
        flip = m_deb[ch] ? (m_hist[ch] == '0) : (m_hist[ch] == '1);
        m_held[ch] = m_deb[ch] && (n - rise_t[ch] == H);
        m_rise[ch] = flip && !m_deb[ch];
        m_fall[ch] = flip && m_deb[ch];
        if (m_rise[ch]) rise_t[ch] = n;
        m_deb[ch] = m_deb[ch] ^ flip;
      end
      m_toga = nta;
      m_togb = ntb;
      m_s2 = m_s1;
      m_s1 = b;
    end
    e.deb = m_deb;
    e.rise = m_rise;
    e.fall = m_fall;
    e.toga = m_toga;
    e.held = m_held;
    e.togb = m_togb;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    b_held_any = b_held_any | (|held_b);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("cycle_a", 16'({deb_a, rise_a, fall_a, tog_a, held_a}), 16'({e.deb, e.rise, e.fall, e.toga, e.held}));
      check("cycle_b", 16'({deb_b, rise_b, fall_b, tog_b, held_b}), 16'({e.deb, e.rise, e.fall, e.togb, 2'b00}));
    end
  end

  initial begin
    int first_hi, nrise, rise_at, nheld, held_at;
    logic tb6, tb7, ch1_any;
    m_hist[0] = '0;
    m_hist[1] = '0;
    rise_t[0] = -1000;
    rise_t[1] = -1000;
    tbl[0]  = '{2'b00, 12, 2'b00, 2'b01, 2'b01, 0, 1, 0};
    tbl[1]  = '{2'b01,  8, 2'b01, 2'b01, 2'b00, 1, 0, 0};
    tbl[2]  = '{2'b00, 12, 2'b00, 2'b00, 2'b00, 0, 1, 0};
    tbl[3]  = '{2'b01, 20, 2'b01, 2'b00, 2'b01, 1, 0, 1};
    tbl[4]  = '{2'b00, 12, 2'b00, 2'b01, 2'b01, 0, 1, 0};
    tbl[5]  = '{2'b01,  2, 2'b00, 2'b01, 2'b01, 0, 0, 0};
    tbl[6]  = '{2'b00,  2, 2'b00, 2'b01, 2'b01, 0, 0, 0};
    tbl[7]  = '{2'b01,  2, 2'b00, 2'b01, 2'b01, 0, 0, 0};
    tbl[8]  = '{2'b00,  2, 2'b00, 2'b01, 2'b01, 0, 0, 0};
    tbl[9]  = '{2'b01, 12, 2'b01, 2'b01, 2'b00, 1, 0, 0};
    tbl[10] = '{2'b00, 12, 2'b00, 2'b00, 2'b00, 0, 1, 1};
    tbl[11] = '{2'b11, 12, 2'b11, 2'b00, 2'b11, 1, 0, 0};
    tbl[12] = '{2'b10, 12, 2'b10, 2'b01, 2'b11, 0, 1, 1};
    tbl[13] = '{2'b00, 12, 2'b00, 2'b11, 2'b11, 0, 0, 0};
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);
    for (int i = 0; i < 4; i++) step(2'b01, 1'b0);
    check("pre_reset_deb", 16'(deb_a), 16'(0));
    step(2'b01, 1'b1);
    check("reset_a", 16'({deb_a, rise_a, fall_a, tog_a, held_a}), 16'(0));
    check("reset_b", 16'({deb_b, rise_b, fall_b, tog_b, held_b}), 16'(0));
    first_hi = 0;
    nrise = 0;
    rise_at = 0;
    nheld = 0;
    held_at = 0;
    tb6 = 1'b1;
    tb7 = 1'b0;
    ch1_any = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step(2'b01, 1'b0);
      if (deb_a[0] && first_hi == 0) first_hi = i;
      if (rise_a[0]) begin
        nrise++;
        rise_at = i;
      end
      if (held_a[0]) begin
        nheld++;
        held_at = i;
      end
      if (i == 6) tb6 = tog_b[0];
      if (i == 7) tb7 = tog_b[0];
      ch1_any = ch1_any | deb_a[1] | rise_a[1];
    end
    check("deb_rise_edge", 16'(first_hi), 16'(6));
    check("rise_count", 16'(nrise), 16'(1));
    check("rise_edge", 16'(rise_at), 16'(6));
    check("held_count", 16'(nheld), 16'(1));
    check("held_edge", 16'(held_at), 16'(16));
    check("tog_press_e6", 16'(tb6), 16'(0));
    check("tog_press_e7", 16'(tb7), 16'(1));
    check("ch1_quiet", 16'(ch1_any), 16'(0));
    check("tog_release_idle", 16'(tog_a), 16'(0));
    for (int r = 0; r < 14; r++) begin
      int nr, nf, nh;
      nr = 0;
      nf = 0;
      nh = 0;
      for (int c = 0; c < tbl[r].cyc; c++) begin
        step(tbl[r].in, 1'b0);
        if (rise_a[0]) nr++;
        if (fall_a[0]) nf++;
        if (held_a[0]) nh++;
      end
      check($sformatf("row%0d_deb", r), 16'(deb_a), 16'(tbl[r].deb));
      check($sformatf("row%0d_tog_rel", r), 16'(tog_a), 16'(tbl[r].toga));
      check($sformatf("row%0d_tog_prs", r), 16'(tog_b), 16'(tbl[r].togb));
      check($sformatf("row%0d_rises", r), 16'(nr), 16'(tbl[r].rises));
      check($sformatf("row%0d_falls", r), 16'(nf), 16'(tbl[r].falls));
      check($sformatf("row%0d_helds", r), 16'(nh), 16'(tbl[r].helds));
    end
    check("hold_disabled", 16'(b_held_any), 16'(0));
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
